sysid_probe_ctrl: RTL and testbench
===================================

Name: sysid_probe_ctrl

Overview:
- Avalon-MM read master that sequences the post-reset identity check of the system ID slave.
- Reads word 0 (system ID) and word 1 (build timestamp), then compares each against the expected value fixed at build time.
- Reports pass/fail and the captured values to the HPS-visible status logic and to board LEDs.
- Retries on timeout, so a slave held in reset or busy does not hang the fabric.

Parameters:
- EXPECTED_ID, 32'hACD51302, value the slave must return at address 0.
- EXPECTED_TS, 32'h54BE9BAE, value the slave must return at address 1.
- TIMEOUT_CYCLES, 256, maximum cycles a single read may stall on waitrequest; range 2..65535.
- MAX_RETRY, 3, extra full sequences attempted after a timeout; range 0..15.
- AUTO_START, 1, when 1, one sequence launches automatically on the first cycle after reset deasserts.

Ports:
- clock  in  1  single system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; launches a sequence when idle.
- m_address  out  1  word select to the sysid slave (0 = ID, 1 = timestamp).
- m_read  out  1  read strobe.
- m_waitrequest  in  1  slave stall; data is valid in the cycle m_read=1 and m_waitrequest=0.
- m_readdata  in  32  slave read data.
- busy  out  1  high while a sequence is in progress.
- done  out  1  single-cycle pulse at sequence end (pass, mismatch or final timeout).
- id_ok  out  1  captured ID == EXPECTED_ID.
- ts_ok  out  1  captured timestamp == EXPECTED_TS.
- timeout_err  out  1  sticky; set when all retries are exhausted.
- id_value  out  32  last captured ID.
- ts_value  out  32  last captured timestamp.

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, state IDLE, retry count 0, timeout counter 0. Reset mid-sequence aborts immediately; m_read drops on the next edge. No done pulse is produced for an aborted sequence.
- States:
  - IDLE -> RD_ID on start=1, or on the first post-reset cycle if AUTO_START=1.
  - RD_ID: m_address=0, m_read=1. When m_waitrequest=0: latch m_readdata into id_value, go to RD_TS.
  - RD_TS: m_address=1, m_read=1. When m_waitrequest=0: latch ts_value, go to CHECK.
  - CHECK (1 cycle): register id_ok and ts_ok from the captured values, go to FIN.
  - FIN (1 cycle): done=1, go to IDLE.
- Sequence entry (start, auto-start, or retry):
  - Clear id_ok, ts_ok and the timeout counter.
  - Clear the retry count only on a fresh start, not on a retry.
  - timeout_err is cleared only by a fresh start.
- Nominal latency with zero wait states: start at cycle 0; RD_ID at 1; RD_TS at 2; CHECK at 3; done pulse at cycle 4.
- m_address and m_read are registered and stay stable while m_waitrequest=1 (Avalon-MM hold rule).
- busy=1 in RD_ID, RD_TS, CHECK and FIN.
- Timeout counter:
  - Increments each cycle in RD_ID or RD_TS while m_waitrequest=1; resets on each accepted read.
  - Reaching TIMEOUT_CYCLES-1 with waitrequest still high: deassert m_read for one cycle.
  - Then, if retry count < MAX_RETRY: increment the retry count and re-enter RD_ID.
  - Otherwise: set timeout_err, id_ok=ts_ok=0, go to FIN.
- Mismatch is not retried. id_ok/ts_ok simply report the comparison, and captured values remain visible.
- start while busy: ignored, no queuing. start in the same cycle as the FIN done pulse: ignored.
- Counter widths: timeout counter is $clog2(TIMEOUT_CYCLES) bits; retry counter is 4 bits. Neither may wrap; both saturate at their terminal value.
- Outputs hold their values in IDLE until the next sequence entry.

Decomposition:
- Package sysid_probe_pkg:
  - state enum {IDLE, RD_ID, RD_TS, CHECK, FIN}.
  - localparams ADDR_ID=1'b0 and ADDR_TS=1'b1.
- One sub-module, probe_timeout_cnt: a loadable saturating counter with enable, clear and terminal-count output, reused for the per-read timeout.
- Retry count stays inline.

Test Plan:
- Zero-wait slave returning 32'hACD51302 and 32'h54BE9BAE, start at cycle 0 -> done pulse at cycle 4; id_ok=1, ts_ok=1, timeout_err=0, busy low at cycle 5.
- Slave returns ID 32'h00000000 -> id_ok=0, ts_ok=1, id_value=0, done pulses once, no retry.
- waitrequest held 5 cycles on each read -> m_address/m_read stable throughout; done at cycle 14; both ok.
- waitrequest stuck high, TIMEOUT_CYCLES=8, MAX_RETRY=2 -> three read attempts, each with one cycle of m_read=0 between; timeout_err=1, id_ok=ts_ok=0, single done pulse.
- reset_n low during RD_TS -> next edge: m_read=0 and all outputs 0; no done pulse. With AUTO_START=1, a new sequence starts after release.
- start re-pulsed while busy, and again coincident with done -> both ignored. A start one cycle after done launches a new sequence and clears timeout_err.

Source files
------------

// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system ID probe sequencer.
// Both read addresses and the sequencer state encoding live here.
package sysid_probe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      RD_TS,
      CHECK,
      FIN
   } state_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam int RETRY_W = 4;

   function automatic logic isReadState(input state_t s);
      return (s == RD_ID) || (s == RD_TS);
   endfunction

endpackage

// File: rtl/probe_timeout_cnt.sv
// Loadable saturating up-counter with enable, clear and terminal-count flag.
// It holds at TERMINAL instead of wrapping.
module probe_timeout_cnt #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] TERMINAL = '1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_loadValue,
   input  logic             i_enable,
   output logic             o_terminal
);

   logic [WIDTH-1:0] r_count;

   assign o_terminal = (r_count == TERMINAL);

   // Clear has priority over load, and load has priority over counting.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_enable && !o_terminal) begin
         r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/sysid_probe_ctrl.sv
// Avalon-MM read master that checks the system ID word and the build timestamp word.
// A stalled read is abandoned after a bounded wait and the whole sequence is retried.
module sysid_probe_ctrl
   import sysid_probe_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
   parameter logic [31:0] EXPECTED_TS    = 32'h54BE9BAE,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter int          MAX_RETRY      = 3,
   parameter int          AUTO_START     = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int                 TO_W        = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]    TO_TERMINAL = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
   localparam logic               AUTO_LAUNCH = (AUTO_START != 0);

   state_t               r_state;
   state_t               w_nextState;
   logic                 r_gap;
   logic                 r_autoPend;
   logic [RETRY_W-1:0]   r_retry;
   logic                 r_mRead;
   logic                 r_mAddr;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_idOk;
   logic                 r_tsOk;
   logic                 r_timeoutErr;
   logic [31:0]          r_idValue;
   logic [31:0]          r_tsValue;

   logic                 w_launch;
   logic                 w_retry;
   logic                 w_capId;
   logic                 w_capTs;
   logic                 w_check;
   logic                 w_fail;
   logic                 w_toFire;
   logic                 w_cntClear;
   logic                 w_cntEn;
   logic                 w_toTerminal;

   probe_timeout_cnt #(
      .WIDTH    (TO_W),
      .TERMINAL (TO_TERMINAL)
   ) u_timeoutCnt (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_clear     (w_cntClear),
      .i_load      (1'b0),
      .i_loadValue ({TO_W{1'b0}}),
      .i_enable    (w_cntEn),
      .o_terminal  (w_toTerminal)
   );

   // r_gap marks the single strobe-low cycle after a timed-out read; the retry
   // or give-up decision is taken at the end of that cycle.
   always_comb begin
      w_nextState = r_state;
      w_launch    = 1'b0;
      w_retry     = 1'b0;
      w_capId     = 1'b0;
      w_capTs     = 1'b0;
      w_check     = 1'b0;
      w_fail      = 1'b0;
      w_toFire    = 1'b0;
      w_cntClear  = 1'b0;
      w_cntEn     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start || r_autoPend) begin
               w_launch    = 1'b1;
               w_cntClear  = 1'b1;
               w_nextState = RD_ID;
            end
         end
         RD_ID, RD_TS: begin
            if (r_gap) begin
               if (r_retry < RETRY_LIMIT) begin
                  w_retry     = 1'b1;
                  w_cntClear  = 1'b1;
                  w_nextState = RD_ID;
               end else begin
                  w_fail      = 1'b1;
                  w_nextState = FIN;
               end
            end else if (!m_waitrequest) begin
               w_cntClear = 1'b1;
               if (r_state == RD_ID) begin
                  w_capId     = 1'b1;
                  w_nextState = RD_TS;
               end else begin
                  w_capTs     = 1'b1;
                  w_nextState = CHECK;
               end
            end else if (w_toTerminal) begin
               w_toFire = 1'b1;
            end else begin
               w_cntEn = 1'b1;
            end
         end
         CHECK: begin
            w_check     = 1'b1;
            w_nextState = FIN;
         end
         FIN: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Bus strobes and status flags are registered from the next state so that
   // they change only on clock edges and hold while the slave stalls.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_gap        <= 1'b0;
         r_autoPend   <= AUTO_LAUNCH;
         r_retry      <= '0;
         r_mRead      <= 1'b0;
         r_mAddr      <= ADDR_ID;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_idOk       <= 1'b0;
         r_tsOk       <= 1'b0;
         r_timeoutErr <= 1'b0;
         r_idValue    <= '0;
         r_tsValue    <= '0;
      end else begin
         r_state    <= w_nextState;
         r_gap      <= w_toFire;
         r_autoPend <= 1'b0;
         r_mRead    <= isReadState(w_nextState) && !w_toFire;
         r_mAddr    <= (w_nextState == RD_TS) ? ADDR_TS : ADDR_ID;
         r_busy     <= (w_nextState != IDLE);
         r_done     <= (w_nextState == FIN);

         if (w_launch) begin
            r_retry      <= '0;
            r_timeoutErr <= 1'b0;
            r_idOk       <= 1'b0;
            r_tsOk       <= 1'b0;
         end
         if (w_retry) begin
            r_retry <= r_retry + {{(RETRY_W-1){1'b0}}, 1'b1};
            r_idOk  <= 1'b0;
            r_tsOk  <= 1'b0;
         end
         if (w_capId) begin
            r_idValue <= m_readdata;
         end
         if (w_capTs) begin
            r_tsValue <= m_readdata;
         end
         if (w_check) begin
            r_idOk <= (r_idValue == EXPECTED_ID);
            r_tsOk <= (r_tsValue == EXPECTED_TS);
         end
         if (w_fail) begin
            r_timeoutErr <= 1'b1;
            r_idOk       <= 1'b0;
            r_tsOk       <= 1'b0;
         end
      end
   end

   assign m_address   = r_mAddr;
   assign m_read      = r_mRead;
   assign busy        = r_busy;
   assign done        = r_done;
   assign id_ok       = r_idOk;
   assign ts_ok       = r_tsOk;
   assign timeout_err = r_timeoutErr;
   assign id_value    = r_idValue;
   assign ts_value    = r_tsValue;

endmodule

// File: tb/tb_sysid_probe_ctrl.sv
// Bench for sysid_probe_ctrl: a transaction-level model of the probe sequence,
// a per-cycle compare process, directed timing checks and a randomized phase.
`timescale 1ns/1ps
module tb_sysid_probe_ctrl;

   localparam logic [31:0] EXP_ID = 32'hACD51302;
   localparam logic [31:0] EXP_TS = 32'h54BE9BAE;
   localparam int          TO_CYC = 8;
   localparam int          MAX_RT = 2;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic        m_waitrequest = 1'b0;
   logic [31:0] m_readdata    = '0;
   logic        m_address, m_read, busy, done, id_ok, ts_ok, timeout_err;
   logic [31:0] id_value, ts_value;

   int total = 0;
   int bad   = 0;

   sysid_probe_ctrl #(
      .EXPECTED_ID    (EXP_ID),
      .EXPECTED_TS    (EXP_TS),
      .TIMEOUT_CYCLES (TO_CYC),
      .MAX_RETRY      (MAX_RT),
      .AUTO_START     (1)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .busy          (busy),
      .done          (done),
      .id_ok         (id_ok),
      .ts_ok         (ts_ok),
      .timeout_err   (timeout_err),
      .id_value      (id_value),
      .ts_value      (ts_value)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Slave: 0 zero-wait, 1 fixed stalls per read, 2 stuck, 3 random stalls, 4 stuck on timestamp only
   int          slaveMode  = 0;
   int          fixedStall = 0;
   int          stallPct   = 50;
   int          stallCnt   = 0;
   logic [31:0] idWord     = EXP_ID;
   logic [31:0] tsWord     = EXP_TS;

   always @(negedge clock) begin : slaveProc
      bit stall;
      if (m_read === 1'b1) begin
         case (slaveMode)
            0:       stall = 1'b0;
            1:       stall = (stallCnt < fixedStall);
            2:       stall = 1'b1;
            3:       stall = ($urandom_range(99, 0) < stallPct);
            default: stall = (m_address === 1'b1);
         endcase
         m_waitrequest = stall;
         if (stall) begin
            stallCnt++;
            m_readdata = $urandom();
         end else begin
            stallCnt   = 0;
            m_readdata = (m_address === 1'b1) ? tsWord : idWord;
         end
      end else begin
         stallCnt      = 0;
         m_waitrequest = 1'($urandom_range(1, 0));
         m_readdata    = $urandom();
      end
   end

   // Model: expected outputs for the cycle following each clock edge.
   bit          modelValid = 1'b0;
   bit          eRead = 0, eAddr = 0, eBusy = 0, eDone = 0, eIdOk = 0, eTsOk = 0, eTerr = 0;
   logic [31:0] eId = '0, eTs = '0;
   bit          sStart, sWait;
   logic [31:0] sData;

   task automatic modelStep(output bit rst);
      @(posedge clock);
      sStart = start;
      sWait  = m_waitrequest;
      sData  = m_readdata;
      rst    = (reset_n == 1'b0);
      if (rst) begin
         eRead = 0; eAddr = 0; eBusy = 0; eDone = 0;
         eIdOk = 0; eTsOk = 0; eTerr = 0; eId = '0; eTs = '0;
         modelValid = 1'b1;
      end
   endtask

   // One read: result 0 = data accepted, 1 = gave up after TO_CYC stalled cycles, 2 = reset
   task automatic modelRead(output int result, output logic [31:0] data);
      int stalls = 0;
      bit rst;
      result = 0;
      data   = '0;
      while (1) begin
         modelStep(rst);
         if (rst) begin result = 2; return; end
         if (!sWait) begin data = sData; return; end
         stalls++;
         if (stalls == TO_CYC) begin result = 1; return; end
      end
   endtask

   task automatic modelSequence(output bit rst);
      int          attempt = 0;
      int          res;
      logic [31:0] d;
      eBusy = 1; eIdOk = 0; eTsOk = 0; eTerr = 0; eRead = 1; eAddr = 0;
      rst = 0;
      while (1) begin
         modelRead(res, d);
         if (res == 2) begin rst = 1; return; end
         if (res == 0) begin
            eId = d; eAddr = 1;
            modelRead(res, d);
            if (res == 2) begin rst = 1; return; end
            if (res == 0) begin
               eTs = d; eRead = 0;
               modelStep(rst); if (rst) return;
               eIdOk = (eId == EXP_ID); eTsOk = (eTs == EXP_TS); eDone = 1;
               modelStep(rst); if (rst) return;
               eDone = 0; eBusy = 0;
               return;
            end
         end
         eRead = 0;
         modelStep(rst); if (rst) return;
         if (attempt < MAX_RT) begin
            attempt++;
            eRead = 1; eAddr = 0; eIdOk = 0; eTsOk = 0;
         end else begin
            eTerr = 1; eIdOk = 0; eTsOk = 0; eDone = 1;
            modelStep(rst); if (rst) return;
            eDone = 0; eBusy = 0;
            return;
         end
      end
   endtask

   initial begin : modelProc
      bit rst, autoPend, launch;
      rst = 0;
      do modelStep(rst); while (!rst);
      forever begin
         autoPend = 1;
         rst = 0;
         while (!rst) begin
            modelStep(rst);
            if (!rst) begin
               launch   = autoPend || sStart;
               autoPend = 0;
               if (launch) modelSequence(rst);
            end
         end
      end
   end

   always @(negedge clock) begin
      if (modelValid) begin
         checkOutput("m_read", m_read, eRead);
         if (eRead) checkOutput("m_address", m_address, eAddr);
         checkOutput("busy", busy, eBusy);
         checkOutput("done", done, eDone);
         checkOutput("id_ok", id_ok, eIdOk);
         checkOutput("ts_ok", ts_ok, eTsOk);
         checkOutput("timeout_err", timeout_err, eTerr);
         checkOutput("id_value", id_value, eId);
         checkOutput("ts_value", ts_value, eTs);
      end
   end

   // Pulses start for one cycle; returns at the negedge of the first sequence cycle.
   task automatic applyStimulus();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      @(negedge clock);
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      checkOutput("idle within budget", busy, 0);
   endtask

   initial begin : mainProc
      int dones, reads, rises, gaps, busyCnt;
      bit prevRead;

      // Reset state, then the automatic post-reset sequence
      waitCycles(3);
      checkOutput("reset m_read", m_read, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset id_value", id_value, 0);
      checkOutput("reset timeout_err", timeout_err, 0);
      reset_n = 1'b1;
      waitCycles(4);
      checkOutput("auto done@4", done, 1);
      checkOutput("model auto done@4", eDone, 1);
      checkOutput("auto id_ok", id_ok, 1);
      checkOutput("auto ts_ok", ts_ok, 1);

      // Zero-wait slave: done at cycle 4, idle at 5
      waitIdle(50);
      applyStimulus();
      waitCycles(3);
      checkOutput("zw done@4", done, 1);
      checkOutput("model zw done@4", eDone, 1);
      checkOutput("zw id_ok", id_ok, 1);
      checkOutput("zw ts_ok", ts_ok, 1);
      checkOutput("zw timeout_err", timeout_err, 0);
      waitCycles(1);
      checkOutput("zw busy@5", busy, 0);

      // Wrong ID word: reported, not retried
      idWord = 32'h0;
      waitIdle(50);
      applyStimulus();
      dones = 0; reads = 0;
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clock);
         if (done === 1'b1) dones++;
         if (m_read === 1'b1) reads++;
      end
      checkOutput("bad id done count", dones, 1);
      checkOutput("bad id read cycles", reads, 2);
      checkOutput("bad id id_ok", id_ok, 0);
      checkOutput("bad id ts_ok", ts_ok, 1);
      checkOutput("bad id id_value", id_value, 32'h0);
      idWord = EXP_ID;

      // Five stalls per read: done at cycle 14
      slaveMode = 1; fixedStall = 5;
      waitIdle(50);
      applyStimulus();
      waitCycles(13);
      checkOutput("stall5 done@14", done, 1);
      checkOutput("model stall5 done@14", eDone, 1);
      checkOutput("stall5 id_ok", id_ok, 1);
      checkOutput("stall5 ts_ok", ts_ok, 1);

      // TIMEOUT_CYCLES-1 stalls is still accepted: done at cycle 18
      fixedStall = TO_CYC - 1;
      waitIdle(50);
      applyStimulus();
      waitCycles(17);
      checkOutput("stall7 done@18", done, 1);
      checkOutput("stall7 timeout_err", timeout_err, 0);

      // Stuck slave: three attempts, each followed by one strobe-low cycle, done at 28
      slaveMode = 2;
      waitIdle(50);
      applyStimulus();
      rises = 0; gaps = 0; dones = 0; prevRead = 0;
      for (int k = 1; k <= 28; k++) begin
         if (k > 1) @(negedge clock);
         if (m_read === 1'b1 && !prevRead) rises++;
         if (busy === 1'b1 && m_read === 1'b0 && done === 1'b0) gaps++;
         prevRead = (m_read === 1'b1);
         if (k < 28 && done === 1'b1) dones++;
      end
      checkOutput("stuck done@28", done, 1);
      checkOutput("model stuck done@28", eDone, 1);
      checkOutput("stuck early done pulses", dones, 0);
      checkOutput("stuck read attempts", rises, 3);
      checkOutput("stuck strobe gaps", gaps, 3);
      checkOutput("stuck timeout_err", timeout_err, 1);
      checkOutput("stuck id_ok", id_ok, 0);
      checkOutput("stuck ts_ok", ts_ok, 0);

      // Start one cycle after done launches and clears timeout_err
      slaveMode = 0;
      @(negedge clock);
      checkOutput("sticky timeout_err in idle", timeout_err, 1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("relaunch busy", busy, 1);
      checkOutput("relaunch clears timeout_err", timeout_err, 0);

      // Start while busy and coincident with done is ignored
      slaveMode = 1; fixedStall = 5;
      waitIdle(50);
      applyStimulus();
      waitCycles(2);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      waitCycles(10);
      checkOutput("ignore done@14", done, 1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("ignore busy after done", busy, 0);
      busyCnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (busy !== 1'b0) busyCnt++;
      end
      checkOutput("ignored starts stay idle", busyCnt, 0);

      // Reset during the timestamp read, then auto-start after release
      waitIdle(50);
      applyStimulus();
      waitCycles(8);
      reset_n = 1'b0;
      @(negedge clock);
      checkOutput("abort m_read", m_read, 0);
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort id_value", id_value, 0);
      checkOutput("abort ts_value", ts_value, 0);
      reset_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (done === 1'b1) dones++;
      end
      checkOutput("post-abort done count", dones, 1);
      checkOutput("post-abort id_ok", id_ok, 1);

      // Randomized sequences with stray starts and occasional resets
      for (int s = 0; s < 60; s++) begin
         waitIdle(200);
         case ($urandom_range(3, 0))
            0:       slaveMode = 0;
            1:       slaveMode = 1;
            2:       slaveMode = 3;
            default: slaveMode = 4;
         endcase
         fixedStall = int'($urandom_range(9, 0));
         stallPct   = int'($urandom_range(95, 40));
         idWord     = ($urandom_range(3, 0) == 0) ? $urandom() : EXP_ID;
         tsWord     = ($urandom_range(3, 0) == 0) ? $urandom() : EXP_TS;
         applyStimulus();
         for (int k = int'($urandom_range(40, 0)); k > 0; k--) begin
            start   = ($urandom_range(9, 0) == 0);
            reset_n = ($urandom_range(49, 0) != 0);
            @(negedge clock);
         end
         start   = 1'b0;
         reset_n = 1'b1;
      end
      waitIdle(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
